// File: rtl/multicycle_main_ctrl.sv
// multicycle_main_ctrl
// Main control FSM for the RV32 multicycle core. It steps each instruction
// through fetch, decode, execute, memory and writeback states, and drives the
// datapath mux selects, write enables and ALU-op class. It also provides:
//   - an optional memory ready handshake that stalls FETCH, MEMREAD and MEMWRITE
//   - illegal-opcode trapping
//   - a one-cycle instruction-retire pulse
//
// Parameters:
//   MEM_WAIT_EN  1: memory states hold until mem_ready; 0: single-cycle memory
//   TRAP_HALT    1: TRAP is terminal until reset; 0: TRAP lasts one cycle
//   EN_UPPER     0: LUI/AUIPC are treated as illegal
//   EN_JALR      0: JALR is treated as illegal
// Ports:
//   clk, reset (synchronous, active-high), op (instr[6:0]), mem_ready
//   MemWrite, RegWrite, IRWrite, AdrSrc, PCUpdate, Branch  - enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp (2b), ImmSrc (3b)   - datapath controls
//   mem_req, illegal_instr, instr_done, state (4b debug)
module multicycle_main_ctrl #(
  parameter bit MEM_WAIT_EN = 1'b0,
  parameter bit TRAP_HALT   = 1'b1,
  parameter bit EN_UPPER    = 1'b1,
  parameter bit EN_JALR     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       PCUpdate,
  output logic       Branch,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       mem_req,
  output logic       illegal_instr,
  output logic       instr_done,
  output logic [3:0] state
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECR     = 4'd6,
    S_ALUWB     = 4'd7,
    S_EXECI     = 4'd8,
    S_JAL       = 4'd9,
    S_BRANCH    = 4'd10,
    S_JALR      = 4'd11,
    S_JALR_LINK = 4'd12,
    S_LUI       = 4'd13,
    S_AUIPC     = 4'd14,
    S_TRAP      = 4'd15
  } state_t;

  state_t state_reg, state_next;
  // Set once TRAP has been occupied for a cycle, so the retire pulse fires
  // only on the first TRAP cycle even when TRAP is terminal.
  logic   trap_seen_reg;
  logic   accept;

  // A memory access completes this cycle (always, when the handshake is off).
  assign accept = (MEM_WAIT_EN == 1'b0) || mem_ready;

  // Debug view of the state reads FETCH while reset is held.
  assign state = reset ? 4'd0 : state_reg;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_FETCH;
      trap_seen_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      trap_seen_reg <= (state_reg == S_TRAP);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:     if (accept) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_REG:            state_next = S_EXECR;
          OP_IMM:            state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = EN_JALR  ? S_JALR  : S_TRAP;
          OP_LUI:            state_next = EN_UPPER ? S_LUI   : S_TRAP;
          OP_AUIPC:          state_next = EN_UPPER ? S_AUIPC : S_TRAP;
          default:           state_next = S_TRAP;
        endcase
      end
      // op[5] separates store from load in the two opcodes that reach here.
      S_MEMADR:    state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:   if (accept) state_next = S_MEMWB;
      S_MEMWB:     state_next = S_FETCH;
      S_MEMWRITE:  if (accept) state_next = S_FETCH;
      S_EXECR:     state_next = S_ALUWB;
      S_EXECI:     state_next = S_ALUWB;
      S_ALUWB:     state_next = S_FETCH;
      S_JAL:       state_next = S_ALUWB;
      S_BRANCH:    state_next = S_FETCH;
      S_JALR:      state_next = S_JALR_LINK;
      S_JALR_LINK: state_next = S_ALUWB;
      S_LUI:       state_next = S_ALUWB;
      S_AUIPC:     state_next = S_ALUWB;
      S_TRAP:      state_next = TRAP_HALT ? S_TRAP : S_FETCH;
      default:     state_next = S_FETCH;
    endcase
  end

  // Output decode; everything is held low while reset is asserted.
  always_comb begin
    MemWrite      = 1'b0;
    RegWrite      = 1'b0;
    IRWrite       = 1'b0;
    AdrSrc        = 1'b0;
    PCUpdate      = 1'b0;
    Branch        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    mem_req       = 1'b0;
    illegal_instr = 1'b0;
    instr_done    = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_FETCH: begin
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          mem_req   = 1'b1;
          IRWrite   = accept;
          PCUpdate  = accept;
        end
        // OldPC + imm: branch/JAL target parked in ALUOut.
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        S_MEMREAD: begin
          AdrSrc  = 1'b1;
          mem_req = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc  = 2'b01;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        // MemWrite is level-held through a stall; memory commits on accept.
        S_MEMWRITE: begin
          AdrSrc     = 1'b1;
          MemWrite   = 1'b1;
          mem_req    = 1'b1;
          instr_done = accept;
        end
        S_EXECR: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b10;
        end
        S_EXECI: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ALUOp   = 2'b10;
        end
        S_ALUWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_JAL: begin
          ALUSrcA  = 2'b01;
          ALUSrcB  = 2'b10;
          PCUpdate = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA    = 2'b10;
          ALUOp      = 2'b01;
          Branch     = 1'b1;
          instr_done = 1'b1;
        end
        // PC <= rs1 + imm straight from the ALU result.
        S_JALR: begin
          ALUSrcA   = 2'b10;
          ALUSrcB   = 2'b01;
          ResultSrc = 2'b10;
          PCUpdate  = 1'b1;
        end
        // Link value OldPC + 4; rs1 was already consumed, so rd == rs1 is safe.
        S_JALR_LINK: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
        end
        S_LUI: begin
          ALUSrcA = 2'b11;
          ALUSrcB = 2'b01;
        end
        S_AUIPC: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
        end
        S_TRAP: begin
          illegal_instr = 1'b1;
          instr_done    = !trap_seen_reg;
        end
        default: ;
      endcase
    end
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: ImmSrc = 3'b000;
      OP_STORE:                 ImmSrc = 3'b001;
      OP_BRANCH:                ImmSrc = 3'b010;
      OP_JAL:                   ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC:         ImmSrc = 3'b100;
      default:                  ImmSrc = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Testbench for multicycle_main_ctrl. Two instances run side by side: one with
// the memory handshake, halting trap and all optional instructions enabled, and
// one with every option off. A reference model walks each instruction through
// its route of states and checks the full output word every cycle.
module tb_multicycle_main_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [6:0] op_a, op_b;
  logic       mr_a, mr_b;

  logic       a_mw, a_rw, a_irw, a_adr, a_pcu, a_br, a_mreq, a_ill, a_done;
  logic [1:0] a_res, a_sa, a_sb, a_aop;
  logic [2:0] a_imm;
  logic [3:0] a_st;
  logic       b_mw, b_rw, b_irw, b_adr, b_pcu, b_br, b_mreq, b_ill, b_done;
  logic [1:0] b_res, b_sa, b_sb, b_aop;
  logic [2:0] b_imm;
  logic [3:0] b_st;

  multicycle_main_ctrl #(.MEM_WAIT_EN(1'b1), .TRAP_HALT(1'b1), .EN_UPPER(1'b1), .EN_JALR(1'b1)) u_a (
    .clk(clk), .reset(reset), .op(op_a), .mem_ready(mr_a),
    .MemWrite(a_mw), .RegWrite(a_rw), .IRWrite(a_irw), .AdrSrc(a_adr), .PCUpdate(a_pcu), .Branch(a_br),
    .ResultSrc(a_res), .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ALUOp(a_aop), .ImmSrc(a_imm),
    .mem_req(a_mreq), .illegal_instr(a_ill), .instr_done(a_done), .state(a_st)
  );

  multicycle_main_ctrl #(.MEM_WAIT_EN(1'b0), .TRAP_HALT(1'b0), .EN_UPPER(1'b0), .EN_JALR(1'b0)) u_b (
    .clk(clk), .reset(reset), .op(op_b), .mem_ready(mr_b),
    .MemWrite(b_mw), .RegWrite(b_rw), .IRWrite(b_irw), .AdrSrc(b_adr), .PCUpdate(b_pcu), .Branch(b_br),
    .ResultSrc(b_res), .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ALUOp(b_aop), .ImmSrc(b_imm),
    .mem_req(b_mreq), .illegal_instr(b_ill), .instr_done(b_done), .state(b_st)
  );

  wire [31:0] obs_a = {8'd0, a_mw, a_rw, a_irw, a_adr, a_pcu, a_br, a_res, a_sa, a_sb, a_aop,
                       a_imm, a_mreq, a_ill, a_done, a_st};
  wire [31:0] obs_b = {8'd0, b_mw, b_rw, b_irw, b_adr, b_pcu, b_br, b_res, b_sa, b_sb, b_aop,
                       b_imm, b_mreq, b_ill, b_done, b_st};

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Instance configuration: index 0 = u_a, 1 = u_b.
  bit p_wait[2]  = '{1'b1, 1'b0};
  bit p_halt[2]  = '{1'b1, 1'b0};
  bit p_upper[2] = '{1'b1, 1'b0};
  bit p_jalr[2]  = '{1'b1, 1'b0};

  // Model: current state, the states still to visit after DECODE, and how
  // many consecutive cycles have been spent in TRAP.
  int m_state[2];
  int m_route[2][4];
  int m_len[2];
  int m_idx[2];
  int m_trap[2];
  int dut_retired[2];
  int exp_retired[2];

  logic [6:0] legal_ops[11] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111,
                                7'b0000000};

  function automatic logic [6:0] rand_op();
    if ($urandom_range(0, 3) == 0) return 7'($urandom);
    return legal_ops[$urandom_range(0, 10)];
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 3'b001;
    if (o == 7'b1100011) return 3'b010;
    if (o == 7'b1101111) return 3'b011;
    if (o == 7'b0110111 || o == 7'b0010111) return 3'b100;
    return 3'b000;
  endfunction

  task automatic set_route(input int i, input int len, input int s0, input int s1, input int s2);
    m_len[i] = len;
    m_route[i][0] = s0;
    m_route[i][1] = s1;
    m_route[i][2] = s2;
  endtask

  // Full list of states an instruction visits after DECODE, before FETCH.
  task automatic build_route(input int i, input logic [6:0] o);
    case (o)
      7'b0000011: set_route(i, 3, 2, 3, 4);
      7'b0100011: set_route(i, 2, 2, 5, 0);
      7'b0110011: set_route(i, 2, 6, 7, 0);
      7'b0010011: set_route(i, 2, 8, 7, 0);
      7'b1100011: set_route(i, 1, 10, 0, 0);
      7'b1101111: set_route(i, 2, 9, 7, 0);
      7'b1100111: if (p_jalr[i]) set_route(i, 3, 11, 12, 7); else set_route(i, 1, 15, 0, 0);
      7'b0110111: if (p_upper[i]) set_route(i, 2, 13, 7, 0); else set_route(i, 1, 15, 0, 0);
      7'b0010111: if (p_upper[i]) set_route(i, 2, 14, 7, 0); else set_route(i, 1, 15, 0, 0);
      default:    set_route(i, 1, 15, 0, 0);
    endcase
  endtask

  function automatic int route_next(input int i);
    int s;
    if (m_idx[i] < m_len[i]) begin
      s = m_route[i][m_idx[i]];
      m_idx[i]++;
    end else begin
      s = 0;
    end
    return s;
  endfunction

  task automatic model_step(input int i, input bit rst, input bit mr, input logic [6:0] o);
    int  cur, nxt;
    bit  acc;
    acc = !p_wait[i] || mr;
    cur = m_state[i];
    nxt = cur;
    if (rst) begin
      nxt = 0;
      m_len[i] = 0;
      m_idx[i] = 0;
    end else begin
      case (cur)
        0:       if (acc) nxt = 1;
        1: begin
          build_route(i, o);
          m_idx[i] = 0;
          nxt = route_next(i);
        end
        3, 5:    if (acc) nxt = route_next(i);
        15:      nxt = p_halt[i] ? 15 : 0;
        default: nxt = route_next(i);
      endcase
    end
    m_trap[i] = (!rst && cur == 15 && nxt == 15) ? m_trap[i] + 1 : 0;
    m_state[i] = nxt;
  endtask

  function automatic logic [31:0] exp_out(input int i, input logic [6:0] o, input bit mr, input bit rst);
    logic mw, rw, irw, adr, pcu, br, mreq, ill, done;
    logic [1:0] res, sa, sb, aop;
    logic [3:0] st;
    bit acc;
    acc = !p_wait[i] || mr;
    {mw, rw, irw, adr, pcu, br, mreq, ill, done} = '0;
    {res, sa, sb, aop} = '0;
    st = rst ? 4'd0 : 4'(m_state[i]);
    if (!rst) begin
      case (m_state[i])
        0:  begin sb = 2'b10; res = 2'b10; mreq = 1; irw = acc; pcu = acc; end
        1:  begin sa = 2'b01; sb = 2'b01; end
        2:  begin sa = 2'b10; sb = 2'b01; end
        3:  begin adr = 1; mreq = 1; end
        4:  begin res = 2'b01; rw = 1; done = 1; end
        5:  begin adr = 1; mw = 1; mreq = 1; done = acc; end
        6:  begin sa = 2'b10; aop = 2'b10; end
        7:  begin rw = 1; done = 1; end
        8:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
        9:  begin sa = 2'b01; sb = 2'b10; pcu = 1; end
        10: begin sa = 2'b10; aop = 2'b01; br = 1; done = 1; end
        11: begin sa = 2'b10; sb = 2'b01; res = 2'b10; pcu = 1; end
        12: begin sa = 2'b01; sb = 2'b10; end
        13: begin sa = 2'b11; sb = 2'b01; end
        14: begin sa = 2'b01; sb = 2'b01; end
        15: begin ill = 1; done = (m_trap[i] == 0); end
        default: ;
      endcase
    end
    return {8'd0, mw, rw, irw, adr, pcu, br, res, sa, sb, aop, imm_of(o), mreq, ill, done, st};
  endfunction

  logic [6:0] dir_a[$];
  logic [6:0] dir_b[$];
  bit         mr_dir_a[$];

  initial begin
    logic [31:0] ea, eb;
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_len[i] = 0; m_idx[i] = 0; m_trap[i] = 0;
      dut_retired[i] = 0; exp_retired[i] = 0;
    end
    // lw, sw (stalled), jalr, lui, beq, add, illegal -> halting trap
    dir_a = '{7'b0000011, 7'b0100011, 7'b1100111, 7'b0110111, 7'b1100011, 7'b0110011, 7'b1111111};
    // lui/jalr/auipc trap here (disabled), illegal traps for one cycle
    dir_b = '{7'b0110111, 7'b1100111, 7'b1111111, 7'b0000011, 7'b0010111, 7'b1100011, 7'b0110011};
    // lw with no stall, then sw: 3 stall cycles in FETCH, 2 in MEMWRITE
    mr_dir_a = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 1};
    reset = 1'b1;
    op_a = 7'd0;
    op_b = 7'd0;
    mr_a = 1'b1;
    mr_b = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      reset = (cyc < 2) || (cyc == 60) || (cyc > 60 && $urandom_range(0, 39) == 0);
      // The instruction register loads as DECODE begins; hold op until the next one.
      if (m_state[0] == 1) op_a = (dir_a.size() > 0) ? dir_a.pop_front() : rand_op();
      if (m_state[1] == 1) op_b = (dir_b.size() > 0) ? dir_b.pop_front() : rand_op();
      if (cyc >= 2 && mr_dir_a.size() > 0) mr_a = mr_dir_a.pop_front();
      else mr_a = ($urandom_range(0, 3) != 0);
      mr_b = 1'($urandom_range(0, 1));
      #1;
      ea = exp_out(0, op_a, mr_a, reset);
      eb = exp_out(1, op_b, mr_b, reset);
      check_eq($sformatf("outs_a c%0d", cyc), obs_a, ea);
      check_eq($sformatf("outs_b c%0d", cyc), obs_b, eb);
      dut_retired[0] += int'(a_done);
      dut_retired[1] += int'(b_done);
      exp_retired[0] += int'(ea[4]);
      exp_retired[1] += int'(eb[4]);
      @(posedge clk);
      model_step(0, reset, mr_a, op_a);
      model_step(1, reset, mr_b, op_b);
    end
    check_eq("retired_a", 32'(dut_retired[0]), 32'(exp_retired[0]));
    check_eq("retired_b", 32'(dut_retired[1]), 32'(exp_retired[1]));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_main_ctrl.md
# multicycle_main_ctrl

Parametrised main control FSM for the RV32 multicycle core; successor to the base fetch/decode/execute controller. Adds JALR, LUI/AUIPC, a 3-bit immediate-select, an optional memory ready handshake that stalls fetch/load/store, illegal-opcode trapping, and an instruction-retire pulse. It drives the datapath mux, enable and ALU-op controls; `ALUDecoder` and the PC/branch logic consume its outputs unchanged.

## Interface
- `MEM_WAIT_EN`, 0: 1 = FETCH/MEMREAD/MEMWRITE hold until `mem_ready`=1; 0 = `mem_ready` ignored, memory is single-cycle.
- `TRAP_HALT`, 1: 1 = TRAP is terminal until reset; 0 = TRAP lasts one cycle, then FETCH.
- `EN_UPPER`, 1: 0 = LUI/AUIPC are illegal.
- `EN_JALR`, 1: 0 = JALR is illegal.
- `clk` in 1: clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 7: instr[6:0] from the instruction register.
- `mem_ready` in 1: memory access completes this cycle.
- `MemWrite`, `RegWrite`, `IRWrite`, `AdrSrc`, `PCUpdate`, `Branch` out 1 each.
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 RD1, 11 zero.
- `ALUSrcB` out 2: 00 WriteData, 01 ImmExt, 10 constant 4.
- `ALUOp` out 2: 00 add, 01 branch compare, 10 funct-decoded.
- `ImmSrc` out 3: 000 I, 001 S, 010 B, 011 J, 100 U.
- `mem_req` out 1: memory access requested.
- `illegal_instr` out 1: high in TRAP.
- `instr_done` out 1: one-cycle retire pulse.
- `state` out 4: current state encoding, debug.

## Operation
- States, 4-bit: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BRANCH 10, JALR 11, JALR_LINK 12, LUI 13, AUIPC 14, TRAP 15.
- All outputs are Moore decodes of `state`, except `ImmSrc` and the `mem_ready` gating.
- `ImmSrc` is combinational from `op` in every state:
  - 0000011, 0010011, 1100111 -> 000; 0100011 -> 001; 1100011 -> 010; 1101111 -> 011; 0110111, 0010111 -> 100; other -> 000.
- Any output not listed for a state is 0.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, mem_req=1. IRWrite=PCUpdate=1 only in the accepting cycle (always when MEM_WAIT_EN=0).
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. This computes the branch/JAL target into ALUOut.
- DECODE transitions:
  - lw/sw -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL.
  - 1100111 -> JALR; 0110111 -> LUI; 0010111 -> AUIPC, each only if its enable is set.
  - Anything else -> TRAP.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00, mem_req=1 -> MEMWB on accept.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, mem_req=1 -> FETCH on accept.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate=1 -> ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, PCUpdate=1 -> JALR_LINK.
- JALR_LINK: ALUSrcA=01, ALUSrcB=10 -> ALUWB. This makes rd = OldPC+4; rd==rs1 is safe because rs1 was already consumed.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH.
- LUI: ALUSrcA=11, ALUSrcB=01 -> ALUWB. AUIPC: ALUSrcA=01, ALUSrcB=01 -> ALUWB.
- TRAP: illegal_instr=1; no write enables asserted.
- instr_done=1 in: MEMWB, ALUWB, BRANCH, MEMWRITE accepting cycle, and the first TRAP cycle. It never pulses twice for one instruction.
- Unreachable or corrupt states are not possible with 16 encodings; the default branch still goes to FETCH with all outputs 0.

## Timing
- Reset:
  - While `reset`=1, every output except `state` and `ImmSrc` is forced to 0, and `state` reads 0.
  - State is FETCH on the first cycle after release.
  - Reset mid-instruction aborts it: no RegWrite/MemWrite in the reset cycle.
- Latency with MEM_WAIT_EN=0, FETCH to retire inclusive: BRANCH 3; R, I, JAL, LUI, AUIPC, sw 4; lw, JALR 5.
- Each cycle of `mem_ready`=0 in FETCH/MEMREAD/MEMWRITE adds one cycle. During the stall, outputs stay stable, and IRWrite/PCUpdate/instr_done stay 0 until accept.
- MemWrite is level-held through the stall; memory commits on the accept cycle.
- `mem_ready` outside the three memory states is ignored.

## Test plan
- Reset then lw (op=0000011), MEM_WAIT_EN=0 -> states 0,1,2,3,4,0; RegWrite and ResultSrc=01 only in state 4; instr_done pulses once.
- MEM_WAIT_EN=1, sw with `mem_ready` low for 3 cycles in FETCH and 2 cycles in MEMWRITE -> IRWrite/PCUpdate pulse once; MemWrite held 3 cycles; 9 cycles to retire.
- JALR (1100111) -> states 0,1,11,12,7; PCUpdate=1 with ResultSrc=10 in state 11; RegWrite only in state 7.
- LUI with EN_UPPER=1 -> state 13 with ALUSrcA=11, ImmSrc=100. With EN_UPPER=0 -> TRAP, illegal_instr=1, no RegWrite.
- op=1111111: with TRAP_HALT=1, the FSM stays in state 15 for 10 cycles; with TRAP_HALT=0, TRAP lasts 1 cycle then FETCH.
- Reset asserted in EXECR -> next state 0, all enables 0 during reset; BEQ (1100011) -> Branch=1, ALUOp=01 for exactly one cycle.
